// File: rtl/cam_bank_sequencer.sv
// Camera capture sequencer: packs 8-bit pixel bytes into little-endian 32-bit
// words and writes them round-robin into four frame-buffer banks.
module cam_bank_sequencer #(
  parameter int BANK_AW = 9,
  parameter int CNT_W   = 16
) (
  input  logic               PCLKI,
  input  logic               WBs_RST_i,
  input  logic               VSYNCI,
  input  logic               HREFI,
  input  logic [7:0]         CAM_D,
  input  logic               cfg_enable_i,
  input  logic               cfg_single_i,
  input  logic [3:0]         bank_release_i,
  output logic [BANK_AW-1:0] ram_wa_o,
  output logic [31:0]        ram_wd_o,
  output logic [3:0]         ram_wen_o,
  output logic [1:0]         cur_bank_o,
  output logic [3:0]         bank_full_o,
  output logic               overflow_o,
  output logic               frame_done_o,
  output logic [CNT_W-1:0]   frame_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_reg;
  logic               vs_prev_reg;
  logic [1:0]         byte_idx_reg;
  logic [BANK_AW-1:0] addr_reg;
  logic [1:0]         cur_bank_reg;
  logic [3:0]         bank_full_reg;
  logic               overflow_reg;
  logic               frame_done_reg;
  logic [CNT_W-1:0]   frame_cnt_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;
  logic [BANK_AW-1:0] ram_wa_reg;
  logic [31:0]        ram_wd_reg;
  logic [3:0]         ram_wen_reg;

  logic               vs_rise;
  logic               vs_fall;
  logic               byte_accept;
  logic               word_done;
  logic               cur_full;
  logic               word_write;
  logic [3:0]         cur_onehot;
  logic [3:0]         set_full;
  logic [31:0]        word_data;

  assign vs_rise     = VSYNCI & ~vs_prev_reg;
  assign vs_fall     = ~VSYNCI & vs_prev_reg;
  assign byte_accept = (state_reg == ST_CAPTURE) && cfg_enable_i && VSYNCI && HREFI;
  assign word_done   = byte_accept && (byte_idx_reg == 2'd3);
  assign cur_onehot  = 4'b0001 << cur_bank_reg;
  assign cur_full    = |(bank_full_reg & cur_onehot);
  assign word_write  = word_done && !cur_full;
  // A completed write at the last address fills the bank; this set beats a release
  assign set_full    = (word_write && (addr_reg == {BANK_AW{1'b1}})) ? cur_onehot : 4'b0000;

  // Byte lanes 0..2 are held until byte 3 arrives and completes the word
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
        lane_reg <= '0;
      end else if (byte_accept && (byte_idx_reg == 2'(gi))) begin
        lane_reg <= CAM_D;
      end
    end
  end

  assign word_data = {CAM_D, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_reg      <= ST_IDLE;
      vs_prev_reg    <= 1'b0;
      byte_idx_reg   <= 2'd0;
      addr_reg       <= '0;
      cur_bank_reg   <= 2'd0;
      bank_full_reg  <= 4'b0000;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      drop_cnt_reg   <= '0;
      ram_wa_reg     <= '0;
      ram_wd_reg     <= '0;
      ram_wen_reg    <= 4'b0000;
    end else begin
      vs_prev_reg    <= VSYNCI;
      frame_done_reg <= 1'b0;
      ram_wen_reg    <= 4'b0000;
      bank_full_reg  <= (bank_full_reg & ~bank_release_i) | set_full;

      if (!cfg_enable_i) begin
        // Disabling drops any partial word; flags and counters stay visible
        state_reg    <= ST_IDLE;
        byte_idx_reg <= 2'd0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg     <= ST_WAIT_VS;
            addr_reg      <= '0;
            cur_bank_reg  <= 2'd0;
            byte_idx_reg  <= 2'd0;
            bank_full_reg <= 4'b0000;
            overflow_reg  <= 1'b0;
            drop_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
          end
          ST_WAIT_VS: begin
            if (vs_rise) begin
              state_reg <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (vs_fall) begin
              byte_idx_reg   <= 2'd0;
              frame_done_reg <= 1'b1;
              frame_cnt_reg  <= frame_cnt_reg + 1'b1;
              state_reg      <= cfg_single_i ? ST_DONE : ST_WAIT_VS;
            end else if (byte_accept) begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
              if (word_done && cur_full) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != {CNT_W{1'b1}}) begin
                  drop_cnt_reg <= drop_cnt_reg + 1'b1;
                end
              end else if (word_write) begin
                ram_wd_reg  <= word_data;
                ram_wa_reg  <= addr_reg;
                ram_wen_reg <= cur_onehot;
                addr_reg    <= addr_reg + 1'b1;
                if (addr_reg == {BANK_AW{1'b1}}) begin
                  cur_bank_reg <= cur_bank_reg + 2'd1;
                end
              end
            end
          end
          default: begin
            state_reg <= ST_DONE;
          end
        endcase
      end
    end
  end

  assign ram_wa_o     = ram_wa_reg;
  assign ram_wd_o     = ram_wd_reg;
  assign ram_wen_o    = ram_wen_reg;
  assign cur_bank_o   = cur_bank_reg;
  assign bank_full_o  = bank_full_reg;
  assign overflow_o   = overflow_reg;
  assign frame_done_o = frame_done_reg;
  assign frame_cnt_o  = frame_cnt_reg;
  assign drop_cnt_o   = drop_cnt_reg;
  assign state_o      = state_reg;

endmodule
